// File: rtl/audio_sched_pkg.sv
// Shared definitions for the audio transfer sequencer: state encoding,
// latency-timer width and the legal latency ranges.
package audio_sched_pkg;

   localparam int TIMER_W = 3;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;
   localparam int FX_LAT_MIN = 0;
   localparam int FX_LAT_MAX = 7;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WAIT_RD = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_FX_WAIT = 3'd4,
      ST_WRITE   = 3'd5
   } state_t;

endpackage

// File: rtl/lat_timer.sv
// Loadable down-counter that times both the FIFO read latency and the
// effect-stage latency; it stops at zero rather than wrapping.
module lat_timer
   import audio_sched_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               dec,
   output logic [TIMER_W-1:0] value,
   output logic               zero
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (load) begin
         value <= load_value;
      end else if (dec && (value != '0)) begin
         value <= value - TIMER_W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/audio_xfer_sched.sv
// Moves one stereo sample at a time from the receive FIFO through the
// effect stage into the transmit FIFO, with bypass, mute and status counters.
module audio_xfer_sched
   import audio_sched_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LAT     = 1,
   parameter int FX_LAT     = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  bypass,
   input  logic                  mute,
   input  logic                  adcfifo_empty,
   output logic                  adcfifo_read,
   input  logic [DATA_WIDTH-1:0] adcfifo_readdata,
   input  logic                  dacfifo_full,
   output logic                  dacfifo_write,
   output logic [DATA_WIDTH-1:0] dacfifo_writedata,
   output logic [DATA_WIDTH-1:0] fx_in,
   input  logic [DATA_WIDTH-1:0] fx_out,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  xfer_cnt,
   output logic [CNT_WIDTH-1:0]  stall_cnt
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_bad
      $error("audio_xfer_sched: RD_LAT out of range");
   end
   if (FX_LAT < FX_LAT_MIN || FX_LAT > FX_LAT_MAX) begin : g_fx_lat_bad
      $error("audio_xfer_sched: FX_LAT out of range");
   end

   localparam logic [TIMER_W-1:0] RD_RELOAD = TIMER_W'(RD_LAT - 1);
   localparam logic [TIMER_W-1:0] FX_RELOAD = TIMER_W'((FX_LAT > 0) ? FX_LAT - 1 : 0);

   state_t             state, state_nx;
   logic               byp_q, mute_q;
   logic               timer_load, timer_dec, timer_zero;
   logic [TIMER_W-1:0] timer_load_val, timer_value;
   logic               write_go;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] sel_wr_data(
      input logic                  m,
      input logic                  b,
      input logic [DATA_WIDTH-1:0] direct,
      input logic [DATA_WIDTH-1:0] effect
   );
      if (m)      return '0;
      else if (b) return direct;
      else        return effect;
   endfunction

   lat_timer u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_load_val),
      .dec        (timer_dec),
      .value      (timer_value),
      .zero       (timer_zero)
   );

   always_comb begin
      state_nx       = state;
      timer_load     = 1'b0;
      timer_load_val = '0;
      timer_dec      = 1'b0;
      write_go       = 1'b0;
      case (state)
         // The write-strobe cycle itself never starts a read, leaving the
         // transmit FIFO a cycle to update its full flag.
         ST_IDLE: begin
            if (enable && !adcfifo_empty && !dacfifo_full && !dacfifo_write)
               state_nx = ST_READ;
         end
         ST_READ: begin
            if (RD_LAT == 1) begin
               state_nx = ST_CAPTURE;
            end else begin
               timer_load     = 1'b1;
               timer_load_val = RD_RELOAD;
               state_nx       = ST_WAIT_RD;
            end
         end
         // Read data lands RD_LAT cycles after the strobe, so leave as the
         // count is about to hit zero.
         ST_WAIT_RD: begin
            timer_dec = 1'b1;
            if (timer_value == TIMER_W'(1))
               state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (byp_q || FX_LAT == 0) begin
               state_nx = ST_WRITE;
            end else begin
               timer_load     = 1'b1;
               timer_load_val = FX_RELOAD;
               state_nx       = ST_FX_WAIT;
            end
         end
         ST_FX_WAIT: begin
            timer_dec = 1'b1;
            if (timer_zero)
               state_nx = ST_WRITE;
         end
         ST_WRITE: begin
            if (!dacfifo_full) begin
               write_go = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= ST_IDLE;
         adcfifo_read      <= 1'b0;
         dacfifo_write     <= 1'b0;
         dacfifo_writedata <= '0;
         fx_in             <= '0;
         busy              <= 1'b0;
         byp_q             <= 1'b0;
         mute_q            <= 1'b0;
         xfer_cnt          <= '0;
         stall_cnt         <= '0;
      end else begin
         state         <= state_nx;
         busy          <= (state_nx != ST_IDLE);
         adcfifo_read  <= (state_nx == ST_READ);
         dacfifo_write <= write_go;
         if (state == ST_READ) begin
            byp_q  <= bypass;
            mute_q <= mute;
         end
         if (state == ST_CAPTURE)
            fx_in <= adcfifo_readdata;
         if (write_go) begin
            dacfifo_writedata <= sel_wr_data(mute_q, byp_q, fx_in, fx_out);
            xfer_cnt          <= xfer_cnt + CNT_WIDTH'(1);
         end
         if (state == ST_WRITE && dacfifo_full)
            stall_cnt <= sat_inc(stall_cnt);
      end
   end

endmodule

// File: tb/tb_audio_xfer_sched.sv
// Bench for audio_xfer_sched: FIFO and effect-stage models, a timeline-level
// reference model checked every cycle, directed cases and a randomized run.
module tb_audio_xfer_sched;

   localparam int RD_LAT = 1;
   localparam int FX_LAT = 2;

   logic        clk, reset, enable, bypass, mute;
   logic        adcfifo_empty, adcfifo_read, dacfifo_full, dacfifo_write, busy;
   logic [31:0] adcfifo_readdata, dacfifo_writedata, fx_in, fx_out;
   logic [15:0] xfer_cnt, stall_cnt;

   audio_xfer_sched #(.DATA_WIDTH(32), .RD_LAT(RD_LAT), .FX_LAT(FX_LAT), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .bypass(bypass), .mute(mute),
      .adcfifo_empty(adcfifo_empty), .adcfifo_read(adcfifo_read),
      .adcfifo_readdata(adcfifo_readdata), .dacfifo_full(dacfifo_full),
      .dacfifo_write(dacfifo_write), .dacfifo_writedata(dacfifo_writedata),
      .fx_in(fx_in), .fx_out(fx_out), .busy(busy),
      .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Receive FIFO: stimulus writes rx_mem/n_push, the pop process owns n_pop.
   logic [31:0] rx_mem [0:255];
   int          n_push = 0;
   int          n_pop  = 0;
   logic [31:0] rx_data = '0;
   assign adcfifo_empty    = (n_push == n_pop);
   assign adcfifo_readdata = rx_data;

   always @(posedge clk) begin
      if (adcfifo_read) begin
         rx_data <= rx_mem[n_pop[7:0]];
         n_pop   <= n_pop + 1;
      end
   end

   // Effect stage: bitwise NOT with FX_LAT=2 register stages.
   logic [31:0] fx_p1 = '0, fx_p2 = '0;
   always @(posedge clk) begin
      fx_p1 <= ~fx_in;
      fx_p2 <= fx_p1;
   end
   assign fx_out = fx_p2;

   // Reference model: tracks the in-flight sample as a timeline of cycle numbers.
   int          cyc = 0;
   logic        exp_rd = 0, exp_wr = 0, exp_busy = 0;
   logic [31:0] exp_wd = '0, exp_fx = '0;
   logic [15:0] exp_x = '0, exp_s = '0;
   bit          m_fl = 0, m_pend = 0;
   int          m_pop = 0, m_rd_at = 0, m_wr_from = 0, m_ready_at = 0;
   logic [31:0] m_smp = '0, m_val = '0;
   logic [31:0] expq[$];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) begin
         exp_rd = 0; exp_wr = 0; exp_busy = 0; exp_wd = '0; exp_fx = '0;
         exp_x = '0; exp_s = '0; m_fl = 0; m_pend = 0; m_ready_at = 0;
      end else begin
         exp_rd = 0;
         exp_wr = 0;
         if (m_pend) begin
            m_pend    = 0;
            m_val     = mute ? 32'h0 : (bypass ? m_smp : ~m_smp);
            m_wr_from = m_rd_at + RD_LAT + (bypass ? 0 : FX_LAT) + 1;
         end else if (m_fl && (cyc - 1 >= m_wr_from)) begin
            if (dacfifo_full) begin
               if (exp_s != 16'hFFFF) exp_s = exp_s + 16'd1;
            end else begin
               exp_wr = 1; exp_wd = m_val; exp_x = exp_x + 16'd1;
               m_fl = 0; m_ready_at = cyc + 2;
               expq.push_back(m_val);
            end
         end else if (!m_fl && cyc >= m_ready_at && enable && (m_pop < n_push) && !dacfifo_full) begin
            exp_rd = 1; m_fl = 1; m_pend = 1;
            m_smp = rx_mem[m_pop[7:0]]; m_pop = m_pop + 1; m_rd_at = cyc;
         end
         if (m_fl && cyc == m_rd_at + RD_LAT + 1) exp_fx = m_smp;
         exp_busy = m_fl;
      end
   end

   // Compare process: every output against the model, once per cycle.
   bit          checking = 0;
   int          n_rd = 0, n_wr = 0, rd_cyc = 0, wr_cyc = 0;
   logic [31:0] outq[$];

   initial forever begin
      @(negedge clk);
      if (checking) begin
         chk("cyc_read",  {31'b0, adcfifo_read},  {31'b0, exp_rd});
         chk("cyc_write", {31'b0, dacfifo_write}, {31'b0, exp_wr});
         chk("cyc_wdata", dacfifo_writedata, exp_wd);
         chk("cyc_fx_in", fx_in, exp_fx);
         chk("cyc_busy",  {31'b0, busy}, {31'b0, exp_busy});
         chk("cyc_xfer",  {16'b0, xfer_cnt},  {16'b0, exp_x});
         chk("cyc_stall", {16'b0, stall_cnt}, {16'b0, exp_s});
      end
      if (adcfifo_read)  begin n_rd++; rd_cyc = cyc; end
      if (dacfifo_write) begin n_wr++; wr_cyc = cyc; outq.push_back(dacfifo_writedata); end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] w);
      rx_mem[n_push[7:0]] = w;
      n_push = n_push + 1;
   endtask

   task automatic wait_rd(input int n0, input string nm);
      for (int i = 0; i < 200 && n_rd == n0; i++) step();
      chk(nm, {31'b0, n_rd != n0}, 32'd1);
   endtask

   task automatic wait_wr(input int n0, input string nm);
      for (int i = 0; i < 300 && n_wr == n0; i++) step();
      chk(nm, {31'b0, n_wr != n0}, 32'd1);
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_read"},  {31'b0, adcfifo_read},  32'd0);
      chk({pfx, "_write"}, {31'b0, dacfifo_write}, 32'd0);
      chk({pfx, "_wdata"}, dacfifo_writedata, 32'd0);
      chk({pfx, "_fx_in"}, fx_in, 32'd0);
      chk({pfx, "_busy"},  {31'b0, busy}, 32'd0);
      chk({pfx, "_xfer"},  {16'b0, xfer_cnt}, 32'd0);
      chk({pfx, "_stall"}, {16'b0, stall_cnt}, 32'd0);
   endtask

   initial begin
      int n0, r0, w0, s0, w_start, p_base, o_base, errs, guard;
      bit en_done;
      logic [31:0] w, o;

      reset = 1; enable = 0; bypass = 0; mute = 0; dacfifo_full = 0;
      repeat (2) step();
      checking = 1;
      step();
      chk_reset_vals("rst");
      reset = 0;
      step();

      // Plain transfer through the NOT effect.
      enable = 1; n0 = n_wr;
      push(32'h1234_5678);
      wait_wr(n0, "t1_timeout");
      chk("t1_latency", wr_cyc - rd_cyc, 32'd5);
      chk("t1_data", dacfifo_writedata, 32'hEDCB_A987);
      chk("t1_xfer", {16'b0, xfer_cnt}, 32'd1);

      // Bypass skips the effect latency.
      bypass = 1; n0 = n_wr;
      push(32'h0001_FFFF);
      wait_wr(n0, "byp_timeout");
      chk("byp_latency", wr_cyc - rd_cyc, 32'd3);
      chk("byp_data", dacfifo_writedata, 32'h0001_FFFF);
      bypass = 0;

      // Mute latched at READ writes zero.
      mute = 1; n0 = n_wr;
      push(32'hCAFE_F00D);
      wait_wr(n0, "mute_timeout");
      chk("mute_data", dacfifo_writedata, 32'h0000_0000);
      mute = 0;

      // Mute raised during FX_WAIT does not touch the in-flight sample.
      n0 = n_rd; w0 = n_wr;
      push(32'hA5A5_0F0F);
      wait_rd(n0, "mtog_rd_timeout");
      step(); step();
      mute = 1;
      wait_wr(w0, "mtog_timeout");
      chk("mtog_data", dacfifo_writedata, 32'h5A5A_F0F0);
      mute = 0;

      // Back-pressure: ten stalled WRITE cycles, then one write of the held data.
      n0 = n_rd; w0 = n_wr; s0 = stall_cnt;
      push(32'h0F1E_2D3C);
      wait_rd(n0, "stall_rd_timeout");
      step();
      dacfifo_full = 1;
      while (cyc < rd_cyc + 14) step();
      dacfifo_full = 0;
      wait_wr(w0, "stall_timeout");
      chk("stall_cnt", {16'b0, stall_cnt} - s0, 32'd10);
      chk("stall_latency", wr_cyc - rd_cyc, 32'd15);
      chk("stall_data", dacfifo_writedata, 32'hF0E1_D2C3);
      repeat (8) step();
      chk("stall_one_write", n_wr - w0, 32'd1);

      // Reset in the middle of a transfer discards the sample.
      n0 = n_rd;
      push(32'h1357_9BDF);
      wait_rd(n0, "rst_rd_timeout");
      step(); step();
      reset = 1;
      #1;
      chk_reset_vals("rstmid");
      step();
      reset = 0;
      w0 = n_wr;
      repeat (12) step();
      chk("rstmid_no_write", n_wr - w0, 32'd0);
      push(32'h2468_ACE0);
      wait_wr(w0, "rstmid_next_timeout");
      chk("rstmid_next_data", dacfifo_writedata, 32'hDB97_531F);
      chk("rstmid_next_xfer", {16'b0, xfer_cnt}, 32'd1);

      // Randomized run: 100 queued samples, random bypass/mute/back-pressure,
      // enable dropped once mid-transfer.
      w_start = n_wr; p_base = n_push; o_base = outq.size();
      for (int i = 0; i < 100; i++) push($urandom);
      en_done = 0; guard = 0;
      while (n_wr < w_start + 100 && guard < 8000) begin
         step();
         guard++;
         if ($urandom_range(0, 9) == 0) bypass = $urandom_range(0, 1);
         mute = ($urandom_range(0, 7) == 0);
         dacfifo_full = ($urandom_range(0, 5) == 0);
         if (!en_done && n_wr >= w_start + 30 && busy) begin
            en_done = 1; enable = 0; dacfifo_full = 0;
            r0 = n_rd; w0 = n_wr;
            repeat (30) step();
            chk("en_drop_reads", n_rd - r0, 32'd0);
            chk("en_drop_writes", n_wr - w0, 32'd1);
            enable = 1;
         end
      end
      dacfifo_full = 0;
      chk("rand_enable_dropped", {31'b0, en_done}, 32'd1);
      chk("rand_count", n_wr - w_start, 32'd100);
      errs = 0;
      for (int i = 0; i < 100; i++) begin
         if (o_base + i < outq.size()) begin
            o = outq[o_base + i];
            w = rx_mem[(p_base + i) % 256];
            if (!(o == w || o == ~w || o == 32'h0)) errs++;
         end else begin
            errs++;
         end
      end
      chk("rand_order", errs, 32'd0);
      errs = 0;
      if (expq.size() != outq.size()) errs++;
      for (int i = 0; i < outq.size() && i < expq.size(); i++)
         if (outq[i] !== expq[i]) errs++;
      chk("seq_vs_model", errs, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
